// File: rtl/song_sequencer_if.sv
// ============================================================================
// Module      : song_sequencer_if
// Description : Control/ROM/score bundle between the song sequencer and its
//               surroundings (buttons, note ROM, score updater, display).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface song_sequencer_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              pause;
    logic [ADDR_W-1:0] romAddr;
    logic [7:0]        romData;
    logic [17:0]       binaryScore;
    logic [3:0]        correctNote;
    logic              noteValid;
    logic              beatTick;
    logic              scoreReset;
    logic [1:0]        state;
    logic              songDone;
    logic [17:0]       highScore;
    logic              newHigh;

    modport master (
        input  start, pause, romData, binaryScore,
        output romAddr, correctNote, noteValid, beatTick, scoreReset,
               state, songDone, highScore, newHigh
    );

    modport slave (
        output start, pause, romData, binaryScore,
        input  romAddr, correctNote, noteValid, beatTick, scoreReset,
               state, songDone, highScore, newHigh
    );
endinterface

`default_nettype wire

// File: rtl/song_sequencer.sv
// ============================================================================
// Module      : song_sequencer
// Description : Game-flow controller: walks the note ROM, times each note in
//               beats, pulses the score reset and keeps the high score.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module song_sequencer #(
    parameter int TICKS_PER_BEAT = 6750000,
    parameter int ADDR_W         = 6,
    parameter int SONG_LEN       = 64
) (
    input  wire logic          clk,
    input  wire logic          reset,
    song_sequencer_if.master   bus
);

    localparam int c_TICK_W = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICKS_PER_BEAT - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_PRE  = c_TICK_W'(TICKS_PER_BEAT - 2);
    localparam logic [ADDR_W-1:0]   c_ADDR_LAST = ADDR_W'(SONG_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state,       w_state;
    logic                r_loadData,    w_loadData;
    logic [ADDR_W-1:0]   r_romAddr,     w_romAddr;
    logic [c_TICK_W-1:0] r_tickCnt,     w_tickCnt;
    logic [3:0]          r_beatCnt,     w_beatCnt;
    logic [3:0]          r_correctNote, w_correctNote;
    logic                r_beatTick,    w_beatTick;
    logic                r_scoreReset,  w_scoreReset;
    logic [17:0]         r_highScore,   w_highScore;
    logic                r_newHigh,     w_newHigh;
    logic                r_cmpPending,  w_cmpPending;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_loadData    <= 1'b0;
            r_romAddr     <= '0;
            r_tickCnt     <= '0;
            r_beatCnt     <= '0;
            r_correctNote <= '0;
            r_beatTick    <= 1'b0;
            r_scoreReset  <= 1'b0;
            r_highScore   <= '0;
            r_newHigh     <= 1'b0;
            r_cmpPending  <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_loadData    <= w_loadData;
            r_romAddr     <= w_romAddr;
            r_tickCnt     <= w_tickCnt;
            r_beatCnt     <= w_beatCnt;
            r_correctNote <= w_correctNote;
            r_beatTick    <= w_beatTick;
            r_scoreReset  <= w_scoreReset;
            r_highScore   <= w_highScore;
            r_newHigh     <= w_newHigh;
            r_cmpPending  <= w_cmpPending;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_loadData    = r_loadData;
        w_romAddr     = r_romAddr;
        w_tickCnt     = r_tickCnt;
        w_beatCnt     = r_beatCnt;
        w_correctNote = r_correctNote;
        w_beatTick    = 1'b0;
        w_scoreReset  = 1'b0;
        w_highScore   = r_highScore;
        w_newHigh     = 1'b0;
        w_cmpPending  = r_cmpPending;

        case (r_state)
            S_IDLE: begin
                w_correctNote = '0;
                if (bus.start) begin
                    w_state      = S_LOAD;
                    w_loadData   = 1'b0;
                    w_romAddr    = '0;
                    w_scoreReset = 1'b1;
                end
            end

            S_LOAD: begin
                // First cycle lets the ROM register the address; data is used on the second.
                if (!r_loadData) begin
                    w_loadData = 1'b1;
                end else begin
                    w_loadData = 1'b0;
                    if (bus.romData[7:4] == 4'd0) begin
                        w_state       = S_DONE;
                        w_correctNote = '0;
                        w_cmpPending  = 1'b1;
                    end else begin
                        w_state       = S_PLAY;
                        w_correctNote = bus.romData[3:0];
                        w_beatCnt     = bus.romData[7:4];
                        w_tickCnt     = '0;
                    end
                end
            end

            S_PLAY: begin
                if (!bus.pause) begin
                    if (r_tickCnt == c_TICK_LAST) begin
                        w_tickCnt = '0;
                        w_beatCnt = r_beatCnt - 4'd1;
                        if (r_beatCnt == 4'd1) begin
                            if (r_romAddr == c_ADDR_LAST) begin
                                w_state       = S_DONE;
                                w_correctNote = '0;
                                w_cmpPending  = 1'b1;
                            end else begin
                                w_state    = S_LOAD;
                                w_loadData = 1'b0;
                                w_romAddr  = r_romAddr + 1'b1;
                            end
                        end
                    end else begin
                        w_tickCnt = r_tickCnt + 1'b1;
                        // Registered so the pulse lands in the terminal-tick cycle itself.
                        w_beatTick = (r_tickCnt == c_TICK_PRE);
                    end
                end
            end

            S_DONE: begin
                w_correctNote = '0;
                if (r_cmpPending) begin
                    w_cmpPending = 1'b0;
                    if (bus.binaryScore > r_highScore) begin
                        w_highScore = bus.binaryScore;
                        w_newHigh   = 1'b1;
                    end
                end
                if (bus.start) begin
                    w_state      = S_LOAD;
                    w_loadData   = 1'b0;
                    w_romAddr    = '0;
                    w_scoreReset = 1'b1;
                end
            end

            default: w_state = S_IDLE;
        endcase
    end

    assign bus.romAddr     = r_romAddr;
    assign bus.correctNote = r_correctNote;
    assign bus.noteValid   = (r_state == S_PLAY);
    assign bus.beatTick    = r_beatTick;
    assign bus.scoreReset  = r_scoreReset;
    assign bus.state       = r_state;
    assign bus.songDone    = (r_state == S_DONE);
    assign bus.highScore   = r_highScore;
    assign bus.newHigh     = r_newHigh;

endmodule

`default_nettype wire

// File: tb/tb_song_sequencer.sv
// ============================================================================
// Module      : tb_song_sequencer
// Description : Directed, table-driven bench for song_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_song_sequencer;

    localparam int TPB = 4;
    localparam int AW  = 4;
    localparam int SL  = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    song_sequencer_if #(.ADDR_W(AW)) bus ();

    song_sequencer #(
        .TICKS_PER_BEAT (TPB),
        .ADDR_W         (AW),
        .SONG_LEN       (SL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] rom [0:15];
    always_ff @(posedge clk) bus.romData <= rom[bus.romAddr];

    typedef struct {
        logic          start;
        logic          pause;
        logic [1:0]    st;
        logic [3:0]    note;
        logic          tick;
        logic          sr;
        logic [AW-1:0] addr;
        logic [17:0]   hs;
        logic          nh;
    } vec_t;

    vec_t vecs[$];
    int   nVec  = 0;
    int   nFail = 0;

    function automatic logic [32:0] outs();
        return {bus.state, bus.correctNote, bus.noteValid, bus.beatTick,
                bus.scoreReset, bus.songDone, bus.romAddr, bus.highScore, bus.newHigh};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        nVec++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic addN(input int n, input logic s, input logic p, input logic [1:0] st,
                        input logic [3:0] note, input logic tk, input logic sr,
                        input logic [AW-1:0] a, input logic [17:0] hs, input logic nh);
        vec_t v;
        v.start = s; v.pause = p; v.st = st; v.note = note; v.tick = tk;
        v.sr = sr; v.addr = a; v.hs = hs; v.nh = nh;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic runVecs(input int lo, input int hi, input string tag);
        logic [32:0] exp;
        for (int i = lo; i < hi; i++) begin
            @(posedge clk); #1;
            bus.start = vecs[i].start;
            bus.pause = vecs[i].pause;
            @(negedge clk);
            exp = {vecs[i].st, vecs[i].note, vecs[i].st == 2'd2, vecs[i].tick, vecs[i].sr,
                   vecs[i].st == 2'd3, vecs[i].addr, vecs[i].hs, vecs[i].nh};
            check($sformatf("%s[%0d]", tag, i - lo), 64'(outs()), 64'(exp));
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.pause = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int k;
        k = 0;
        while (!bus.songDone && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!bus.songDone) begin
            nVec++;
            nFail++;
            $display("FAIL %s: songDone not seen, got 0, expected 1 within 200 cycles", tag);
        end
    endtask

    int aEnd, bEnd, eEnd, pulses;

    initial begin
        // Run 1: basic song, score 100, from IDLE.
        addN(1, 1,0, 2'd0, 4'd0,  0,0, 4'd0, 18'd0,   0);
        addN(1, 0,0, 2'd1, 4'd0,  0,1, 4'd0, 18'd0,   0);
        addN(1, 0,0, 2'd1, 4'd0,  0,0, 4'd0, 18'd0,   0);
        addN(3, 0,0, 2'd2, 4'd8,  0,0, 4'd0, 18'd0,   0);
        addN(1, 0,0, 2'd2, 4'd8,  1,0, 4'd0, 18'd0,   0);
        addN(3, 0,0, 2'd2, 4'd8,  0,0, 4'd0, 18'd0,   0);
        addN(1, 0,0, 2'd2, 4'd8,  1,0, 4'd0, 18'd0,   0);
        addN(2, 0,0, 2'd1, 4'd8,  0,0, 4'd1, 18'd0,   0);
        addN(3, 0,0, 2'd2, 4'd10, 0,0, 4'd1, 18'd0,   0);
        addN(1, 0,0, 2'd2, 4'd10, 1,0, 4'd1, 18'd0,   0);
        addN(2, 0,0, 2'd1, 4'd10, 0,0, 4'd2, 18'd0,   0);
        addN(1, 0,0, 2'd3, 4'd0,  0,0, 4'd2, 18'd0,   0);
        addN(1, 0,0, 2'd3, 4'd0,  0,0, 4'd2, 18'd100, 1);
        addN(1, 0,0, 2'd3, 4'd0,  0,0, 4'd2, 18'd100, 0);
        aEnd = vecs.size();
        // Run 2: restart from DONE, pause in cycles 5-9, score 50.
        addN(1, 1,0, 2'd3, 4'd0,  0,0, 4'd2, 18'd100, 0);
        addN(1, 0,0, 2'd1, 4'd0,  0,1, 4'd0, 18'd100, 0);
        addN(1, 0,0, 2'd1, 4'd0,  0,0, 4'd0, 18'd100, 0);
        addN(2, 0,0, 2'd2, 4'd8,  0,0, 4'd0, 18'd100, 0);
        addN(5, 0,1, 2'd2, 4'd8,  0,0, 4'd0, 18'd100, 0);
        addN(1, 0,0, 2'd2, 4'd8,  0,0, 4'd0, 18'd100, 0);
        addN(1, 0,0, 2'd2, 4'd8,  1,0, 4'd0, 18'd100, 0);
        addN(3, 0,0, 2'd2, 4'd8,  0,0, 4'd0, 18'd100, 0);
        addN(1, 0,0, 2'd2, 4'd8,  1,0, 4'd0, 18'd100, 0);
        addN(2, 0,0, 2'd1, 4'd8,  0,0, 4'd1, 18'd100, 0);
        addN(3, 0,0, 2'd2, 4'd10, 0,0, 4'd1, 18'd100, 0);
        addN(1, 0,0, 2'd2, 4'd10, 1,0, 4'd1, 18'd100, 0);
        addN(2, 0,0, 2'd1, 4'd10, 0,0, 4'd2, 18'd100, 0);
        addN(2, 0,0, 2'd3, 4'd0,  0,0, 4'd2, 18'd100, 0);
        bEnd = vecs.size();
        // Length limit: no terminator, SONG_LEN = 3, durations 1.
        addN(1, 1,0, 2'd0, 4'd0,  0,0, 4'd0, 18'd0,   0);
        addN(1, 0,0, 2'd1, 4'd0,  0,1, 4'd0, 18'd0,   0);
        addN(1, 0,0, 2'd1, 4'd0,  0,0, 4'd0, 18'd0,   0);
        addN(3, 0,0, 2'd2, 4'd1,  0,0, 4'd0, 18'd0,   0);
        addN(1, 0,0, 2'd2, 4'd1,  1,0, 4'd0, 18'd0,   0);
        addN(2, 0,0, 2'd1, 4'd1,  0,0, 4'd1, 18'd0,   0);
        addN(3, 0,0, 2'd2, 4'd2,  0,0, 4'd1, 18'd0,   0);
        addN(1, 0,0, 2'd2, 4'd2,  1,0, 4'd1, 18'd0,   0);
        addN(2, 0,0, 2'd1, 4'd2,  0,0, 4'd2, 18'd0,   0);
        addN(3, 0,0, 2'd2, 4'd3,  0,0, 4'd2, 18'd0,   0);
        addN(1, 0,0, 2'd2, 4'd3,  1,0, 4'd2, 18'd0,   0);
        addN(2, 0,0, 2'd3, 4'd0,  0,0, 4'd2, 18'd0,   0);
        eEnd = vecs.size();

        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rom[0] = 8'h28; rom[1] = 8'h1A; rom[2] = 8'h00;

        bus.start       = 1'b1;
        bus.pause       = 1'b0;
        bus.binaryScore = 18'd100;
        reset           = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'(outs()), 64'd0);
        reset     = 1'b0;
        bus.start = 1'b0;

        runVecs(0, aEnd, "run1");
        bus.binaryScore = 18'd50;
        runVecs(aEnd, bEnd, "run2_pause");

        // Run 3: equal score must not update.
        bus.binaryScore = 18'd100;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        pulses = 0;
        @(negedge clk);
        waitDone("run3_done");
        repeat (2) begin
            @(negedge clk);
            if (bus.newHigh) pulses++;
        end
        check("run3_highScore", 64'(bus.highScore), 64'd100);
        check("run3_newHigh_pulses", 64'(pulses), 64'd0);

        // Run 4: higher score, start held on the first DONE cycle.
        bus.binaryScore = 18'd101;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        waitDone("run4_done");
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("run4_state_load", 64'(bus.state), 64'd1);
        check("run4_highScore", 64'(bus.highScore), 64'd101);
        check("run4_newHigh", 64'(bus.newHigh), 64'd1);
        check("run4_scoreReset", 64'(bus.scoreReset), 64'd1);

        // Reset in the middle of PLAY.
        repeat (4) @(negedge clk);
        check("pre_reset_play", 64'(bus.state), 64'd2);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_midplay", 64'(outs()), 64'd0);

        rom[0] = 8'h11; rom[1] = 8'h12; rom[2] = 8'h13; rom[3] = 8'h14;
        bus.binaryScore = 18'd0;
        runVecs(bEnd, eEnd, "len_limit");

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule

`default_nettype wire
